data_mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port 8x256 data memory.
- Requester 0 is the core load/store stage; requester 1 is the bulk-copy/debug engine.
- Drives the memory's MemRead, MemWrite, Address and DataSrc, and returns the registered DataMemOut to the winning requester.
- Round-robin fairness, an optional lock for atomic read-modify-write sequences, and a bounded lock timeout.

---
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port data memory.
// Handshake: rX_req is valid and rX_gnt the same-cycle ready; an access is performed exactly in a cycle with rX_req && rX_gnt, and a read returns one cycle later on rX_rvalid/rX_rdata.
interface data_mem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          r0_req;
   logic          r0_we;
   logic          r0_lock;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata;
   logic          r0_gnt;
   logic          r0_rvalid;
   logic [DW-1:0] r0_rdata;

   logic          r1_req;
   logic          r1_we;
   logic          r1_lock;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata;
   logic          r1_gnt;
   logic          r1_rvalid;
   logic [DW-1:0] r1_rdata;

   logic          MemRead;
   logic          MemWrite;
   logic [AW-1:0] Address;
   logic [DW-1:0] DataSrc;
   logic [DW-1:0] DataMemOut;

   // master: the requesters plus the memory; slave: the arbiter
   modport master (
      output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  MemRead, MemWrite, Address, DataSrc,
      output DataMemOut
   );

   modport slave (
      input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output MemRead, MemWrite, Address, DataSrc,
      input  DataMemOut
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with bounded lock for two requesters sharing a single-port data memory.
// Grants are combinational; read data returns registered one cycle after the grant.
module data_mem_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int MAX_LOCK   = 8,
   parameter int RESET_PRIO = 0
) (
   input  logic                 CLK,
   input  logic                 Reset,
   data_mem_arbiter_if.slave    bus,
   output logic [1:0]           o_dbg_owner
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_0    = 2'd1,
      OWN_1    = 2'd2
   } owner_t;

   owner_t        r_owner;
   logic          r_last;
   logic [7:0]    r_lock_cnt;
   logic          r_rv0;
   logic          r_rv1;
   logic [DW-1:0] r_rd0;
   logic [DW-1:0] r_rd1;

   logic          w_at_max;
   logic          w_rr0;
   logic          w_rr1;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_gnt;
   logic          w_we;
   logic          w_lock;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   owner_t        w_gnt_owner;

   assign w_at_max = (r_lock_cnt == 8'(MAX_LOCK));

   // Tie goes to the side that was not granted last
   assign w_rr0 = bus.r0_req && (!bus.r1_req || r_last);
   assign w_rr1 = bus.r1_req && (!bus.r0_req || !r_last);

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!Reset) begin
         case (r_owner)
            OWN_0: begin
               if (w_at_max && bus.r1_req) begin
                  w_gnt0 = w_rr0;
                  w_gnt1 = w_rr1;
               end else begin
                  w_gnt0 = bus.r0_req;
               end
            end
            OWN_1: begin
               if (w_at_max && bus.r0_req) begin
                  w_gnt0 = w_rr0;
                  w_gnt1 = w_rr1;
               end else begin
                  w_gnt1 = bus.r1_req;
               end
            end
            default: begin
               w_gnt0 = w_rr0;
               w_gnt1 = w_rr1;
            end
         endcase
      end
   end

   assign w_gnt       = w_gnt0 | w_gnt1;
   assign w_we        = w_gnt1 ? bus.r1_we    : bus.r0_we;
   assign w_lock      = w_gnt1 ? bus.r1_lock  : bus.r0_lock;
   assign w_addr      = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
   assign w_wdata     = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
   assign w_gnt_owner = w_gnt1 ? OWN_1 : OWN_0;

   assign bus.r0_gnt    = w_gnt0;
   assign bus.r1_gnt    = w_gnt1;
   assign bus.MemRead   = w_gnt & ~w_we;
   assign bus.MemWrite  = w_gnt & w_we;
   assign bus.Address   = w_gnt ? w_addr : '0;
   assign bus.DataSrc   = (w_gnt && w_we) ? w_wdata : '0;

   assign bus.r0_rvalid = r_rv0;
   assign bus.r1_rvalid = r_rv1;
   assign bus.r0_rdata  = r_rd0;
   assign bus.r1_rdata  = r_rd1;
   assign o_dbg_owner   = r_owner;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_owner    <= OWN_NONE;
         r_last     <= (RESET_PRIO == 0) ? 1'b1 : 1'b0;
         r_lock_cnt <= 8'd0;
         r_rv0      <= 1'b0;
         r_rv1      <= 1'b0;
         r_rd0      <= '0;
         r_rd1      <= '0;
      end else begin
         r_rv0 <= w_gnt0 & ~bus.r0_we;
         r_rv1 <= w_gnt1 & ~bus.r1_we;
         if (w_gnt0 && !bus.r0_we) r_rd0 <= bus.DataMemOut;
         if (w_gnt1 && !bus.r1_we) r_rd1 <= bus.DataMemOut;
         if (w_gnt) begin
            r_last <= w_gnt1;
            if (w_lock) begin
               r_owner <= w_gnt_owner;
               // A fresh owner (including after a forced break) starts counting at 1
               if (r_owner == w_gnt_owner)
                  r_lock_cnt <= w_at_max ? r_lock_cnt : r_lock_cnt + 8'd1;
               else
                  r_lock_cnt <= 8'd1;
            end else begin
               r_owner    <= OWN_NONE;
               r_lock_cnt <= 8'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: reset, latency, round-robin, lock, timeout, reset mid-lock.
module tb_data_mem_arbiter;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [1:0] dbg_owner;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];

   logic [7:0]   mem [0:255];
   logic [255:0] written;

   always #5 CLK = ~CLK;

   data_mem_arbiter_if bus ();

   data_mem_arbiter #(
      .AW(8), .DW(8), .MAX_LOCK(4), .RESET_PRIO(0)
   ) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .bus         (bus),
      .o_dbg_owner (dbg_owner)
   );

   // Memory model: unwritten locations read as addr ^ 8'h3C
   always @(posedge CLK) begin
      if (Reset) begin
         written <= '0;
      end else if (bus.MemWrite) begin
         mem[bus.Address]     <= bus.DataSrc;
         written[bus.Address] <= 1'b1;
      end
   end
   assign bus.DataMemOut = written[bus.Address] ? mem[bus.Address] : (bus.Address ^ 8'h3C);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_r0(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
      bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
      bus.r0_addr = addr; bus.r0_wdata = wdata;
   endtask

   task automatic set_r1(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
      bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
      bus.r1_addr = addr; bus.r1_wdata = wdata;
   endtask

   task automatic idle();
      set_r0(0, 0, 0, 8'h00, 8'h00);
      set_r1(0, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      idle();
      step();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      idle();

      // Reset held with both requesting
      set_r0(1, 0, 0, 8'h20, 8'h00);
      set_r1(1, 0, 0, 8'h21, 8'h00);
      step();
      for (int i = 0; i < 2; i++) begin
         sample();
         check("rst_gnt0", bus.r0_gnt, 0);
         check("rst_gnt1", bus.r1_gnt, 0);
         check("rst_memrd", bus.MemRead, 0);
         check("rst_memwr", bus.MemWrite, 0);
         check("rst_rv0", bus.r0_rvalid, 0);
         check("rst_rv1", bus.r1_rvalid, 0);
         check("rst_owner", dbg_owner, 0);
         step();
      end
      Reset = 1'b0;
      sample();
      check("first_tie_gnt0", bus.r0_gnt, 1);
      check("first_tie_gnt1", bus.r1_gnt, 0);
      check("first_tie_memrd", bus.MemRead, 1);
      check("first_tie_addr", bus.Address, 8'h20);
      step();
      idle();
      sample();
      check("first_rv0", bus.r0_rvalid, 1);
      check("first_rd0", bus.r0_rdata, 8'h1C);
      check("first_rv1", bus.r1_rvalid, 0);
      step();

      // Write then read-after-write latency
      do_reset();
      set_r0(1, 1, 0, 8'h10, 8'hA5);
      sample();
      check("wr_gnt0", bus.r0_gnt, 1);
      check("wr_memwr", bus.MemWrite, 1);
      check("wr_memrd", bus.MemRead, 0);
      check("wr_addr", bus.Address, 8'h10);
      check("wr_src", bus.DataSrc, 8'hA5);
      step();
      set_r0(1, 0, 0, 8'h10, 8'h00);
      sample();
      check("raw_memrd", bus.MemRead, 1);
      check("raw_wr_no_rv", bus.r0_rvalid, 0);
      step();
      idle();
      sample();
      check("raw_rv0", bus.r0_rvalid, 1);
      check("raw_rd0", bus.r0_rdata, 8'hA5);
      check("raw_rv1", bus.r1_rvalid, 0);
      check("idle_memrd", bus.MemRead, 0);
      check("idle_addr", bus.Address, 0);
      step();
      sample();
      check("rv_pulse", bus.r0_rvalid, 0);
      check("rd_hold", bus.r0_rdata, 8'hA5);
      step();

      // Round-robin with both reading every cycle
      do_reset();
      set_r0(1, 0, 0, 8'h40, 8'h00);
      set_r1(1, 0, 0, 8'h81, 8'h00);
      for (int k = 0; k < 7; k++) begin
         if (k == 6) idle();
         sample();
         if (k < 6) begin
            check("rr_gnt0", bus.r0_gnt, (k % 2 == 0));
            check("rr_gnt1", bus.r1_gnt, (k % 2 == 1));
            exp_q.push_back((k % 2 == 0) ? 8'h7C : 8'hBD);
         end
         if (k > 0) begin
            check("rr_rv0", bus.r0_rvalid, ((k - 1) % 2 == 0));
            check("rr_rv1", bus.r1_rvalid, ((k - 1) % 2 == 1));
            if (exp_q.size() == 0) check("rr_q_empty", 1, 0);
            else check("rr_rdata", ((k - 1) % 2 == 0) ? bus.r0_rdata : bus.r1_rdata,
                       exp_q.pop_front());
         end
         step();
      end

      // Lock held by r1 while r0 waits
      do_reset();
      set_r0(1, 0, 0, 8'h05, 8'h00);
      sample();
      check("lk_pre_gnt0", bus.r0_gnt, 1);
      step();
      for (int c = 0; c < 3; c++) begin
         set_r0(1, 0, 0, 8'h06, 8'h00);
         set_r1(1, 1, 1, 8'h50 + 8'(c), 8'h11 + 8'(c));
         sample();
         check("lk_gnt0", bus.r0_gnt, 0);
         check("lk_gnt1", bus.r1_gnt, 1);
         check("lk_memwr", bus.MemWrite, 1);
         if (c > 0) check("lk_owner", dbg_owner, 2);
         step();
      end
      set_r1(0, 0, 0, 8'h00, 8'h00);
      sample();
      check("lk_idle_gnt0", bus.r0_gnt, 0);
      check("lk_idle_gnt1", bus.r1_gnt, 0);
      check("lk_idle_owner", dbg_owner, 2);
      step();
      set_r1(1, 0, 0, 8'h52, 8'h00);
      sample();
      check("lk_unlock_gnt1", bus.r1_gnt, 1);
      check("lk_unlock_gnt0", bus.r0_gnt, 0);
      step();
      sample();
      check("lk_after_gnt0", bus.r0_gnt, 1);
      check("lk_after_gnt1", bus.r1_gnt, 0);
      check("lk_after_owner", dbg_owner, 0);
      check("lk_rv1", bus.r1_rvalid, 1);
      check("lk_rd1", bus.r1_rdata, 8'h13);
      step();

      // Lock timeout forces a break after MAX_LOCK = 4 grants
      do_reset();
      set_r0(1, 0, 1, 8'h07, 8'h00);
      set_r1(1, 0, 0, 8'h08, 8'h00);
      for (int k = 0; k < 6; k++) begin
         sample();
         check("to_gnt0", bus.r0_gnt, (k != 4));
         check("to_gnt1", bus.r1_gnt, (k == 4));
         if (k == 4) check("to_owner_held", dbg_owner, 1);
         if (k == 5) check("to_owner_free", dbg_owner, 0);
         step();
      end

      // Reset pulse during a locked read
      do_reset();
      set_r0(1, 0, 1, 8'h09, 8'h00);
      for (int k = 0; k < 2; k++) begin
         sample();
         check("rml_gnt0", bus.r0_gnt, 1);
         step();
      end
      Reset = 1'b1;
      sample();
      check("rml_rst_gnt0", bus.r0_gnt, 0);
      check("rml_rst_memrd", bus.MemRead, 0);
      step();
      Reset = 1'b0;
      set_r0(0, 0, 0, 8'h00, 8'h00);
      set_r1(1, 0, 0, 8'h0A, 8'h00);
      sample();
      check("rml_rv0", bus.r0_rvalid, 0);
      check("rml_owner", dbg_owner, 0);
      check("rml_gnt1", bus.r1_gnt, 1);
      step();
      idle();
      sample();
      check("rml_rv1", bus.r1_rvalid, 1);
      check("rml_rd1", bus.r1_rdata, 8'h36);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
